rd_req_tag_alloc: RTL and testbench
===================================

// Module: rd_req_tag_alloc
// PURPOSE
//  Sits between read_request and the PCIe core read-request AXIS port. Assigns a free PCIe tag to every sub-request
//  (tuser[103:96] arrives as 0), records per-tag context for the completion path, and frees tags on completion.
//  Stalls the stream when no tag is free. This backpressure feeds read_request's tready.
// PARAMETERS
//  TAG_NUM  32   number of tags managed; tags 0..TAG_NUM-1; power of 2, max 256
//  TAG_W    5    log2(TAG_NUM)
//  DATA_W   `DMA_DATA_W    AXIS tdata width
//  KEEP_W   `DMA_KEEP_W    AXIS tkeep width
//  TUSER_W  `AXIS_TUSER_W  AXIS tuser width (128)
// PORTS
//  dma_clk          in   1        clock
//  rst              in   1        asynchronous, active-high reset
//  s_axis_tvalid    in   1        sub-request from read_request (one beat each)
//  s_axis_tlast     in   1        always 1 on valid beats
//  s_axis_tdata     in   DATA_W   passed through
//  s_axis_tuser     in   TUSER_W  {chnl_num[127:120], last_sub_req[119], rsv, type[107:104], tag[103:96], addr[95:32], rsv, dw_len[18:8], fbe, lbe}
//  s_axis_tkeep     in   KEEP_W   passed through
//  s_axis_tready    out  1        accept
//  m_axis_tvalid/tlast/tdata/tuser/tkeep  out  1/1/DATA_W/TUSER_W/KEEP_W  to PCIe core, tag inserted
//  m_axis_tready    in   1        core accept
//  rls_valid        in   1        completion path: all data for rls_tag received
//  rls_tag          in   TAG_W    tag to free
//  lkp_tag          in   TAG_W    context lookup address
//  lkp_info         out  27       {chnl_num[26:19], last_sub_req[18], dw_len[17:7], addr[6:0]}; registered, 1-cycle latency
//  tag_free_cnt     out  TAG_W+1  number of free tags
//  rls_err          out  1        sticky: released tag that was not allocated
// BEHAVIOUR
//  - Reset (async, rst=1): free bitmap all 1s; tag_free_cnt=TAG_NUM; m_axis_tvalid=0; output regs 0; lkp_info=0; rls_err=0.
//  - Free bitmap: one bit per tag, 1 = free. Alloc picks the lowest-index free bit (priority encoder).
//  - Output stage is a single register. s_axis_tready = (|free_bitmap) & (~m_axis_tvalid | m_axis_tready). Combinational, no dependency on s_axis_tvalid.
//  - On s_axis_tvalid & s_axis_tready:
//    - load the output reg with the input beat, tuser[103:96] replaced by {(8-TAG_W)'b0, tag};
//    - clear that bitmap bit;
//    - write the context table[tag] = {chnl_num, last_sub_req, dw_len, addr[6:0]}.
//    Latency is one cycle, and full throughput (1 beat/clk) while tags remain.
//  - m_axis_tvalid holds until m_axis_tready. Output fields stay stable while tvalid & !tready.
//  - Release: on rls_valid, set bitmap[rls_tag]. If that bit was already 1, the bitmap is unchanged and rls_err sets (sticky until reset).
//  - Same-cycle alloc and release:
//    - both take effect;
//    - the encoder uses pre-release bitmap, so a released tag is allocatable next cycle at earliest;
//    - tag_free_cnt is updated by +1-1 = no change.
//  - tag_free_cnt = popcount-equivalent counter: +1 on a valid release, -1 on alloc, both = hold. Never exceeds TAG_NUM and never goes below 0.
//  - Empty pool (bitmap all 0): s_axis_tready=0. The held input is not consumed. The first release re-enables ready on the following cycle.
//  - lkp_info <= table[lkp_tag] every cycle. A write and a lookup of the same tag in the same cycle return the old content.
//  - Context table is plain registers or distributed RAM. No reset is needed on its contents.
//  - Reset mid-operation: all tags free, the in-flight output beat is dropped, no outstanding state is kept.
// TESTING
//  1. Post-reset, single beat with tuser dw_len=16, chnl 3 -> m_axis one cycle later with tuser[103:96]=0; tag_free_cnt 32->31; lkp_tag=0 gives chnl 3, dw_len 16.
//  2. 32 back-to-back beats with m_axis_tready=1 -> tags 0..31 in order. The 33rd beat sees s_axis_tready=0 and tag_free_cnt=0. rls_tag=7 -> next accepted beat gets tag 7.
//  3. m_axis_tready=0 for 5 cycles with 2 beats pending -> the first beat stays stable on m_axis and the second is not accepted (s_axis_tready=0). Release tready -> both emerge in order, tags 0,1.
//  4. Same cycle: alloc (lowest free = 4) plus rls_tag=2 -> beat gets tag 4, count unchanged, next alloc gets tag 2.
//  5. rls_tag=9 while tag 9 is free -> rls_err=1, stays 1; bitmap and count unchanged.
//  6. Assert rst with 10 tags outstanding and m_axis_tvalid=1 -> immediately m_axis_tvalid=0; after deassert tag_free_cnt=32 and the next alloc is tag 0.

Source files
------------

// File: rtl/rd_req_tag_alloc.sv
// PCIe read-request tag allocator: stamps a free tag onto each sub-request beat,
// records per-tag completion context and recycles tags on completion release.
module rd_req_tag_alloc #(
    parameter int TAG_NUM = 32,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 256,
    parameter int KEEP_W  = 32,
    parameter int TUSER_W = 128
) (
    input  logic               dma_clk,
    input  logic               rst,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    input  logic [DATA_W-1:0]  s_axis_tdata,
    input  logic [TUSER_W-1:0] s_axis_tuser,
    input  logic [KEEP_W-1:0]  s_axis_tkeep,
    output logic               s_axis_tready,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic [TUSER_W-1:0] m_axis_tuser,
    output logic [KEEP_W-1:0]  m_axis_tkeep,
    input  logic               m_axis_tready,
    input  logic               rls_valid,
    input  logic [TAG_W-1:0]   rls_tag,
    input  logic [TAG_W-1:0]   lkp_tag,
    output logic [26:0]        lkp_info,
    output logic [TAG_W:0]     tag_free_cnt,
    output logic               rls_err
);

    localparam int CTX_W = 27;

    logic [TAG_NUM-1:0] free_bitmap_reg, free_bitmap_next;
    logic [TAG_W:0]     free_cnt_reg, free_cnt_next;
    logic               m_valid_reg, m_last_reg;
    logic [DATA_W-1:0]  m_data_reg;
    logic [TUSER_W-1:0] m_user_reg, tagged_tuser;
    logic [KEEP_W-1:0]  m_keep_reg;
    logic [CTX_W-1:0]   lkp_info_reg, ctx_new;
    logic               rls_err_reg;
    logic [CTX_W-1:0]   ctx_table [TAG_NUM];
    logic [TAG_W-1:0]   alloc_tag;
    logic               accept, rls_hit, rls_miss;

    // Lowest-index free tag wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        alloc_tag = '0;
        for (int i = TAG_NUM - 1; i >= 0; i--) begin
            if (free_bitmap_reg[i]) alloc_tag = TAG_W'(i);
        end
    end

    assign s_axis_tready = (|free_bitmap_reg) & (~m_valid_reg | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign rls_hit       = rls_valid & ~free_bitmap_reg[rls_tag];
    assign rls_miss      = rls_valid &  free_bitmap_reg[rls_tag];

    // A valid release always targets an allocated bit, so it can never collide with the allocated one.
    always_comb begin
        free_bitmap_next = free_bitmap_reg;
        if (accept)  free_bitmap_next[alloc_tag] = 1'b0;
        if (rls_hit) free_bitmap_next[rls_tag]   = 1'b1;
    end

    always_comb begin
        free_cnt_next = free_cnt_reg;
        case ({accept, rls_hit})
            2'b10:   free_cnt_next = free_cnt_reg - 1'b1;
            2'b01:   free_cnt_next = free_cnt_reg + 1'b1;
            default: free_cnt_next = free_cnt_reg;
        endcase
    end

    always_comb begin
        tagged_tuser          = s_axis_tuser;
        tagged_tuser[103:96]  = 8'(alloc_tag);
    end

    assign ctx_new = {s_axis_tuser[127:120], s_axis_tuser[119], s_axis_tuser[18:8], s_axis_tuser[38:32]};

    always_ff @(posedge dma_clk or posedge rst) begin
        if (rst) begin
            free_bitmap_reg <= '1;
            free_cnt_reg    <= (TAG_W+1)'(TAG_NUM);
            m_valid_reg     <= 1'b0;
            m_last_reg      <= 1'b0;
            m_data_reg      <= '0;
            m_user_reg      <= '0;
            m_keep_reg      <= '0;
            lkp_info_reg    <= '0;
            rls_err_reg     <= 1'b0;
        end else begin
            free_bitmap_reg <= free_bitmap_next;
            free_cnt_reg    <= free_cnt_next;
            lkp_info_reg    <= ctx_table[lkp_tag];
            if (rls_miss) rls_err_reg <= 1'b1;
            if (accept) begin
                m_valid_reg <= 1'b1;
                m_last_reg  <= s_axis_tlast;
                m_data_reg  <= s_axis_tdata;
                m_user_reg  <= tagged_tuser;
                m_keep_reg  <= s_axis_tkeep;
            end else if (m_axis_tready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    // Context storage is RAM-like and intentionally left out of reset.
    always_ff @(posedge dma_clk) begin
        if (accept) ctx_table[alloc_tag] <= ctx_new;
    end

    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tlast  = m_last_reg;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tuser  = m_user_reg;
    assign m_axis_tkeep  = m_keep_reg;
    assign lkp_info      = lkp_info_reg;
    assign tag_free_cnt  = free_cnt_reg;
    assign rls_err       = rls_err_reg;

endmodule

// File: tb/tb_rd_req_tag_alloc.sv
// Self-checking bench for rd_req_tag_alloc: directed vector table, corner-case
// sequences and randomized traffic against a tag-pool reference model.
module tb_rd_req_tag_alloc;

    localparam int TAG_NUM = 32;
    localparam int TAG_W   = 5;
    localparam int DATA_W  = 256;
    localparam int KEEP_W  = 32;
    localparam int TUSER_W = 128;

    logic               dma_clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_axis_tvalid = 1'b0, s_axis_tlast = 1'b1;
    logic [DATA_W-1:0]  s_axis_tdata = '0;
    logic [TUSER_W-1:0] s_axis_tuser = '0;
    logic [KEEP_W-1:0]  s_axis_tkeep = '0;
    logic               s_axis_tready;
    logic               m_axis_tvalid, m_axis_tlast;
    logic [DATA_W-1:0]  m_axis_tdata;
    logic [TUSER_W-1:0] m_axis_tuser;
    logic [KEEP_W-1:0]  m_axis_tkeep;
    logic               m_axis_tready = 1'b1;
    logic               rls_valid = 1'b0;
    logic [TAG_W-1:0]   rls_tag = '0, lkp_tag = '0;
    logic [26:0]        lkp_info;
    logic [TAG_W:0]     tag_free_cnt;
    logic               rls_err;

    rd_req_tag_alloc #(
        .TAG_NUM(TAG_NUM), .TAG_W(TAG_W), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .TUSER_W(TUSER_W)
    ) dut (
        .dma_clk(dma_clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .s_axis_tuser(s_axis_tuser), .s_axis_tkeep(s_axis_tkeep), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tkeep(m_axis_tkeep), .m_axis_tready(m_axis_tready),
        .rls_valid(rls_valid), .rls_tag(rls_tag), .lkp_tag(lkp_tag), .lkp_info(lkp_info),
        .tag_free_cnt(tag_free_cnt), .rls_err(rls_err)
    );

    always #5 dma_clk = ~dma_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: tag pool as a plain array of "free" flags plus shadow context.
    bit                 free_m [TAG_NUM];
    logic [26:0]        ctx_m [TAG_NUM];
    bit                 ctx_known [TAG_NUM];
    bit                 e_mv, e_last, e_err, e_lkp_known;
    logic [TUSER_W-1:0] e_tuser;
    logic [DATA_W-1:0]  e_tdata;
    logic [KEEP_W-1:0]  e_tkeep;
    logic [26:0]        e_lkp;

    typedef struct {
        int sv, mr, rv, rt, lt, chnl, dw;
        int e_sr, e_mv, e_tag, e_cnt, e_lchk, e_lchnl, e_ldw;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_free();
        int n = 0;
        for (int i = 0; i < TAG_NUM; i++) n += int'(free_m[i]);
        return n;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < TAG_NUM; i++) if (free_m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAG_NUM; i++) free_m[i] = 1'b1;
        e_mv = 1'b0; e_err = 1'b0; e_lkp = '0; e_lkp_known = 1'b1;
    endtask

    task automatic set_beat(input int chnl, input int dw);
        for (int i = 0; i < DATA_W / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
        for (int i = 0; i < TUSER_W / 32; i++) s_axis_tuser[i*32 +: 32] = $urandom;
        s_axis_tuser[103:96]  = 8'h00;
        s_axis_tuser[127:120] = 8'(chnl);
        s_axis_tuser[18:8]    = 11'(dw);
        s_axis_tkeep          = KEEP_W'($urandom);
        s_axis_tlast          = 1'b1;
    endtask

    // One clock: compare outputs against the model at the falling edge, then advance the model.
    task automatic step();
        int  lf;
        bit  rdy, acc, was_free;
        @(negedge dma_clk);
        lf  = lowest_free();
        rdy = (lf >= 0) && (!e_mv || m_axis_tready);
        check("s_tready", 256'(s_axis_tready), 256'(rdy));
        check("m_tvalid", 256'(m_axis_tvalid), 256'(e_mv));
        if (e_mv) begin
            check("m_tuser", 256'(m_axis_tuser), 256'(e_tuser));
            check("m_tdata", m_axis_tdata, e_tdata);
            check("m_tkeep", 256'(m_axis_tkeep), 256'(e_tkeep));
            check("m_tlast", 256'(m_axis_tlast), 256'(e_last));
        end
        check("free_cnt", 256'(tag_free_cnt), 256'(count_free()));
        check("rls_err", 256'(rls_err), 256'(e_err));
        if (e_lkp_known) check("lkp_info", 256'(lkp_info), 256'(e_lkp));

        acc         = s_axis_tvalid && rdy;
        e_lkp_known = ctx_known[lkp_tag];
        e_lkp       = ctx_m[lkp_tag];
        was_free    = free_m[rls_tag];
        if (rls_valid && was_free) e_err = 1'b1;
        if (acc) begin
            e_mv    = 1'b1;
            e_tuser = s_axis_tuser;
            e_tuser[103:96] = 8'(lf);
            e_tdata = s_axis_tdata;
            e_tkeep = s_axis_tkeep;
            e_last  = s_axis_tlast;
            ctx_m[lf] = {s_axis_tuser[127:120], s_axis_tuser[119], s_axis_tuser[18:8], s_axis_tuser[38:32]};
            ctx_known[lf] = 1'b1;
            free_m[lf] = 1'b0;
        end else if (m_axis_tready) begin
            e_mv = 1'b0;
        end
        if (rls_valid && !was_free) free_m[rls_tag] = 1'b1;
        @(posedge dma_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0; rls_valid = 1'b0; m_axis_tready = 1'b1; lkp_tag = '0;
        model_reset();
        repeat (2) @(posedge dma_clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 1, 0, 0, 0, 3, 16,  1, 0, 0, 32, 0, 0, 0};
        vecs[1] = '{0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 31, 0, 0, 0};
        vecs[2] = '{0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 31, 1, 3, 16};
        vecs[3] = '{1, 0, 0, 0, 0, 5, 8,   1, 0, 0, 31, 0, 0, 0};
        vecs[4] = '{1, 0, 0, 0, 0, 6, 9,   0, 1, 1, 30, 0, 0, 0};
        vecs[5] = '{1, 1, 0, 0, 1, 6, 9,   1, 1, 1, 30, 0, 0, 0};
        vecs[6] = '{0, 1, 0, 0, 1, 0, 0,   1, 1, 2, 29, 1, 5, 8};
        vecs[7] = '{1, 1, 1, 1, 2, 7, 4,   1, 0, 0, 29, 1, 5, 8};
        vecs[8] = '{1, 1, 0, 0, 2, 8, 5,   1, 1, 3, 29, 1, 6, 9};
        vecs[9] = '{0, 1, 0, 0, 0, 0, 0,   1, 1, 1, 28, 1, 6, 9};
        for (int i = 0; i < TAG_NUM; i++) begin ctx_known[i] = 1'b0; ctx_m[i] = '0; end

        do_reset();
        check("reset_cnt", 256'(tag_free_cnt), 256'(32));
        check("reset_mvalid", 256'(m_axis_tvalid), 256'(0));
        check("reset_lkp", 256'(lkp_info), 256'(0));

        // Directed vector table
        for (int v = 0; v < 10; v++) begin
            s_axis_tvalid = 1'(vecs[v].sv);
            m_axis_tready = 1'(vecs[v].mr);
            rls_valid     = 1'(vecs[v].rv);
            rls_tag       = TAG_W'(vecs[v].rt);
            lkp_tag       = TAG_W'(vecs[v].lt);
            if (vecs[v].sv != 0 && !(v == 4 || v == 5)) set_beat(vecs[v].chnl, vecs[v].dw);
            if (v == 4) set_beat(vecs[v].chnl, vecs[v].dw);
            #1;
            check("vec_s_tready", 256'(s_axis_tready), 256'(vecs[v].e_sr));
            check("vec_m_tvalid", 256'(m_axis_tvalid), 256'(vecs[v].e_mv));
            if (vecs[v].e_mv != 0) check("vec_m_tag", 256'(m_axis_tuser[103:96]), 256'(vecs[v].e_tag));
            check("vec_free_cnt", 256'(tag_free_cnt), 256'(vecs[v].e_cnt));
            if (vecs[v].e_lchk != 0) begin
                check("vec_lkp_chnl", 256'(lkp_info[26:19]), 256'(vecs[v].e_lchnl));
                check("vec_lkp_dwlen", 256'(lkp_info[17:7]), 256'(vecs[v].e_ldw));
            end
            step();
        end
        rls_valid = 1'b0;

        // Exhaust the pool, then recycle tag 7
        do_reset();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < TAG_NUM; i++) begin
            set_beat(i, i + 1);
            step();
            check("seq_tag", 256'(m_axis_tuser[103:96]), 256'(i));
        end
        set_beat(40, 4);
        check("empty_ready", 256'(s_axis_tready), 256'(0));
        check("empty_cnt", 256'(tag_free_cnt), 256'(0));
        step();
        rls_valid = 1'b1; rls_tag = 5'd7;
        step();
        rls_valid = 1'b0;
        check("refill_ready", 256'(s_axis_tready), 256'(1));
        step();
        check("recycled_tag", 256'(m_axis_tuser[103:96]), 256'(7));
        s_axis_tvalid = 1'b0;
        step();

        // Backpressure hold: first beat stable, second beat blocked
        do_reset();
        begin
            logic [DATA_W-1:0] a_data, b_data;
            m_axis_tready = 1'b0; s_axis_tvalid = 1'b1;
            set_beat(1, 2); a_data = s_axis_tdata;
            step();
            set_beat(2, 3); b_data = s_axis_tdata;
            for (int i = 0; i < 5; i++) begin
                step();
                check("hold_tag", 256'(m_axis_tuser[103:96]), 256'(0));
                check("hold_data", m_axis_tdata, a_data);
                check("hold_ready", 256'(s_axis_tready), 256'(0));
            end
            m_axis_tready = 1'b1;
            step();
            check("second_tag", 256'(m_axis_tuser[103:96]), 256'(1));
            check("second_data", m_axis_tdata, b_data);
            s_axis_tvalid = 1'b0;
            step();
            check("drain_valid", 256'(m_axis_tvalid), 256'(0));
        end

        // Same-cycle alloc and release
        do_reset();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin set_beat(i, 1); step(); end
        set_beat(9, 9); rls_valid = 1'b1; rls_tag = 5'd2;
        step();
        rls_valid = 1'b0;
        check("both_tag", 256'(m_axis_tuser[103:96]), 256'(4));
        check("both_cnt", 256'(tag_free_cnt), 256'(28));
        set_beat(9, 10);
        step();
        check("after_both_tag", 256'(m_axis_tuser[103:96]), 256'(2));
        s_axis_tvalid = 1'b0;
        step();

        // Release of a free tag
        rls_valid = 1'b1; rls_tag = 5'd9;
        step();
        rls_valid = 1'b0;
        check("rls_err_set", 256'(rls_err), 256'(1));
        check("rls_err_cnt", 256'(tag_free_cnt), 256'(27));
        repeat (3) step();
        check("rls_err_sticky", 256'(rls_err), 256'(1));

        // Reset mid-operation
        do_reset();
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin set_beat(i, 2); step(); end
        s_axis_tvalid = 1'b0;
        check("pre_rst_valid", 256'(m_axis_tvalid), 256'(1));
        rst = 1'b1;
        #1;
        check("async_rst_valid", 256'(m_axis_tvalid), 256'(0));
        check("async_rst_cnt", 256'(tag_free_cnt), 256'(32));
        model_reset();
        @(posedge dma_clk);
        #1 rst = 1'b0;
        s_axis_tvalid = 1'b1; set_beat(4, 4);
        step();
        s_axis_tvalid = 1'b0;
        check("post_rst_tag", 256'(m_axis_tuser[103:96]), 256'(0));
        check("post_rst_cnt", 256'(tag_free_cnt), 256'(31));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            s_axis_tvalid = ($urandom_range(0, 3) != 0);
            if (s_axis_tvalid) set_beat($urandom_range(0, 255), $urandom_range(0, 2047));
            m_axis_tready = ($urandom_range(0, 3) != 0);
            lkp_tag       = TAG_W'($urandom);
            rls_valid     = ($urandom_range(0, 2) == 0);
            rls_tag       = TAG_W'($urandom);
            if ($urandom_range(0, 19) != 0) begin
                int start = $urandom_range(0, TAG_NUM - 1);
                for (int k = 0; k < TAG_NUM; k++) begin
                    if (!free_m[(start + k) % TAG_NUM]) begin
                        rls_tag = TAG_W'((start + k) % TAG_NUM);
                        break;
                    end
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
